// File: rtl/time_set_entry.sv
// Digit-by-digit 12-hour time entry: validates hh:mm:ss AM/PM from switch digits
// and pulses a one-cycle load of the assembled time; mirrors the running time when idle.
module time_set_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       accept,
    input  logic       cancel,
    input  logic [3:0] digit,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hr,
    input  logic       cur_AMPM,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       AMPM,
    output logic       load,
    output logic       editing,
    output logic [2:0] field,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HR_T   = 3'd1,
        HR_U   = 3'd2,
        MIN_T  = 3'd3,
        MIN_U  = 3'd4,
        SEC_T  = 3'd5,
        SEC_U  = 3'd6,
        AMPM_S = 3'd7
    } state_t;

    state_t     state, state_next;
    logic [3:0] t, t_next;
    logic [5:0] sec_next, min_next;
    logic [4:0] hr_next;
    logic       ampm_next, load_next, err_next, editing_next;

    logic       start_prev, accept_prev, cancel_prev;
    logic       start_edge, accept_edge, cancel_edge;
    logic       digit_ok;
    logic [6:0] pair;

    assign start_edge  = start  & ~start_prev;
    assign accept_edge = accept & ~accept_prev;
    assign cancel_edge = cancel & ~cancel_prev;

    // Two-digit value of the field being completed, formed at 7 bits then truncated on store.
    assign pair = 7'(t) * 7'd10 + 7'(digit);

    always_comb begin
        case (state)
            HR_T:          digit_ok = (digit <= 4'd1);
            HR_U:          digit_ok = (t == 4'd0) ? (digit >= 4'd1 && digit <= 4'd9)
                                                  : (t == 4'd1 && digit <= 4'd2);
            MIN_T, SEC_T:  digit_ok = (digit <= 4'd5);
            MIN_U, SEC_U:  digit_ok = (digit <= 4'd9);
            AMPM_S:        digit_ok = (digit <= 4'd1);
            default:       digit_ok = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        t_next     = t;
        sec_next   = sec;
        min_next   = min;
        hr_next    = hr;
        ampm_next  = AMPM;
        load_next  = 1'b0;
        err_next   = 1'b0;

        if (state == IDLE) begin
            sec_next  = cur_sec;
            min_next  = cur_min;
            hr_next   = cur_hr;
            ampm_next = cur_AMPM;
            if (start_edge)
                state_next = HR_T;
        end else if (cancel_edge) begin
            state_next = IDLE;
            sec_next   = cur_sec;
            min_next   = cur_min;
            hr_next    = cur_hr;
            ampm_next  = cur_AMPM;
        end else if (accept_edge) begin
            if (!digit_ok) begin
                err_next = 1'b1;
            end else begin
                case (state)
                    HR_T:   begin t_next = digit;        state_next = HR_U;   end
                    HR_U:   begin hr_next = pair[4:0];   state_next = MIN_T;  end
                    MIN_T:  begin t_next = digit;        state_next = MIN_U;  end
                    MIN_U:  begin min_next = pair[5:0];  state_next = SEC_T;  end
                    SEC_T:  begin t_next = digit;        state_next = SEC_U;  end
                    SEC_U:  begin sec_next = pair[5:0];  state_next = AMPM_S; end
                    AMPM_S: begin
                        ampm_next  = digit[0];
                        load_next  = 1'b1;
                        state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        editing_next = (state_next != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            t           <= 4'd0;
            sec         <= 6'd0;
            min         <= 6'd0;
            hr          <= 5'd12;
            AMPM        <= 1'b0;
            load        <= 1'b0;
            err         <= 1'b0;
            editing     <= 1'b0;
            start_prev  <= 1'b0;
            accept_prev <= 1'b0;
            cancel_prev <= 1'b0;
        end else begin
            state       <= state_next;
            t           <= t_next;
            sec         <= sec_next;
            min         <= min_next;
            hr          <= hr_next;
            AMPM        <= ampm_next;
            load        <= load_next;
            err         <= err_next;
            editing     <= editing_next;
            start_prev  <= start;
            accept_prev <= accept;
            cancel_prev <= cancel;
        end
    end

    assign field = state;

endmodule

// File: tb/tb_time_set_entry.sv
// Self-checking bench for time_set_entry: directed test-plan scenarios followed by random
// button/digit traffic, all compared every cycle against a field-range reference model.
module tb_time_set_entry;

    logic       clk = 1'b0;
    logic       rst, start, accept, cancel, cur_AMPM;
    logic [3:0] digit;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hr;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       AMPM, load, editing, err;
    logic [2:0] field;

    int n_vec = 0;
    int n_err = 0;

    time_set_entry dut (
        .clk(clk), .rst(rst), .start(start), .accept(accept), .cancel(cancel),
        .digit(digit), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
        .cur_AMPM(cur_AMPM), .sec(sec), .min(min), .hr(hr), .AMPM(AMPM),
        .load(load), .editing(editing), .field(field), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: position 0 = idle, 1..7 = hr tens/units, min tens/units, sec tens/units, meridiem.
    int m_pos, m_tens, m_sec, m_min, m_hr, m_ampm, m_load, m_err;
    bit p_start, p_accept, p_cancel;

    function automatic bit entry_ok(input int pos, input int tens, input int d);
        int lo, hi;
        lo = (pos <= 2) ? 1 : 0;
        hi = (pos <= 2) ? 12 : 59;
        if (pos == 7)     return d <= 1;
        if (pos % 2 == 1) return d * 10 <= hi;
        return d <= 9 && tens * 10 + d >= lo && tens * 10 + d <= hi;
    endfunction

    always @(posedge clk) begin
        bit se, ae, ce;
        int d;
        se = start & ~p_start;
        ae = accept & ~p_accept;
        ce = cancel & ~p_cancel;
        d  = int'(digit);
        if (rst) begin
            m_pos = 0; m_tens = 0; m_sec = 0; m_min = 0; m_hr = 12; m_ampm = 0;
            m_load = 0; m_err = 0;
            p_start = 0; p_accept = 0; p_cancel = 0;
        end else begin
            m_load = 0;
            m_err  = 0;
            if (m_pos == 0 || ce) begin
                m_sec = cur_sec; m_min = cur_min; m_hr = cur_hr; m_ampm = cur_AMPM;
                m_pos = (m_pos == 0 && se) ? 1 : 0;
            end else if (ae) begin
                if (!entry_ok(m_pos, m_tens, d)) begin
                    m_err = 1;
                end else begin
                    case (m_pos)
                        2: m_hr  = m_tens * 10 + d;
                        4: m_min = m_tens * 10 + d;
                        6: m_sec = m_tens * 10 + d;
                        7: begin m_ampm = d % 2; m_load = 1; end
                        default: m_tens = d;
                    endcase
                    m_pos = (m_pos == 7) ? 0 : m_pos + 1;
                end
            end
            p_start = start; p_accept = accept; p_cancel = cancel;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare every output with the model away from the edge.
    task automatic tick(input bit s, input bit a, input bit c, input bit r, input logic [3:0] d);
        start = s; accept = a; cancel = c; rst = r; digit = d;
        @(negedge clk);
        check("sec",     8'(sec),     8'(m_sec));
        check("min",     8'(min),     8'(m_min));
        check("hr",      8'(hr),      8'(m_hr));
        check("AMPM",    8'(AMPM),    8'(m_ampm));
        check("load",    8'(load),    8'(m_load));
        check("err",     8'(err),     8'(m_err));
        check("field",   8'(field),   8'(m_pos));
        check("editing", 8'(editing), 8'(m_pos != 0));
    endtask

    task automatic idle_tick();
        tick(0, 0, 0, 0, 4'd0);
    endtask

    task automatic press_start();
        tick(1, 0, 0, 0, 4'd0);
        idle_tick();
    endtask

    task automatic enter(input logic [3:0] d);
        tick(0, 1, 0, 0, d);
        tick(0, 0, 0, 0, d);
    endtask

    task automatic press_cancel();
        tick(0, 0, 1, 0, 4'd0);
        idle_tick();
    endtask

    initial begin
        logic [3:0] seq [7];
        seq = '{4'd1, 4'd1, 4'd5, 4'd9, 4'd5, 4'd8, 4'd1};
        cur_sec = 6'd9; cur_min = 6'd7; cur_hr = 5'd3; cur_AMPM = 1'b1;

        // Reset with running time 3:07:09 PM held on the inputs.
        tick(0, 0, 0, 1, 4'd0);
        check("rst_hr", 8'(hr), 8'd12);
        check("rst_min", 8'(min), 8'd0);
        check("rst_sec", 8'(sec), 8'd0);
        check("rst_ampm", 8'(AMPM), 8'd0);
        check("rst_load", 8'(load), 8'd0);
        check("rst_editing", 8'(editing), 8'd0);
        idle_tick();
        check("mirror_hr", 8'(hr), 8'd3);
        check("mirror_min", 8'(min), 8'd7);
        check("mirror_sec", 8'(sec), 8'd9);
        check("mirror_ampm", 8'(AMPM), 8'd1);

        // Full entry of 11:59:58 PM.
        press_start();
        check("start_field", 8'(field), 8'd1);
        for (int i = 0; i < 6; i++) enter(seq[i]);
        tick(0, 1, 0, 0, seq[6]);
        check("commit_field", 8'(field), 8'd0);
        check("commit_load", 8'(load), 8'd1);
        check("commit_hr", 8'(hr), 8'd11);
        check("commit_min", 8'(min), 8'd59);
        check("commit_sec", 8'(sec), 8'd58);
        check("commit_ampm", 8'(AMPM), 8'd1);
        idle_tick();
        check("load_single", 8'(load), 8'd0);

        // Hour 13 rejected, 12 accepted.
        press_start();
        enter(4'd1);
        tick(0, 1, 0, 0, 4'd3);
        check("hr13_err", 8'(err), 8'd1);
        check("hr13_field", 8'(field), 8'd2);
        idle_tick();
        enter(4'd2);
        check("hr12_val", 8'(hr), 8'd12);
        check("hr12_field", 8'(field), 8'd3);
        press_cancel();

        // Hour 00, minute tens 6, hour tens 12 all rejected.
        press_start();
        enter(4'd0);
        tick(0, 1, 0, 0, 4'd0);
        check("hr00_err", 8'(err), 8'd1);
        check("hr00_field", 8'(field), 8'd2);
        idle_tick();
        enter(4'd5);
        tick(0, 1, 0, 0, 4'd6);
        check("min6_err", 8'(err), 8'd1);
        check("min6_field", 8'(field), 8'd3);
        idle_tick();
        press_cancel();
        press_start();
        tick(0, 1, 0, 0, 4'd12);
        check("dig12_err", 8'(err), 8'd1);
        check("dig12_field", 8'(field), 8'd1);
        idle_tick();
        press_cancel();

        // Cancel and accept on the same edge in MIN_U.
        press_start();
        enter(4'd1); enter(4'd0); enter(4'd3);
        check("pre_cancel_field", 8'(field), 8'd4);
        tick(0, 1, 1, 0, 4'd2);
        check("cancel_field", 8'(field), 8'd0);
        check("cancel_load", 8'(load), 8'd0);
        check("cancel_err", 8'(err), 8'd0);
        check("cancel_hr", 8'(hr), 8'd3);
        idle_tick();

        // Held accept gives a single action.
        press_start();
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 4'd1);
        check("held_field", 8'(field), 8'd2);
        idle_tick();

        // Reset in SEC_U discards the edit.
        enter(4'd0); enter(4'd3); enter(4'd0); enter(4'd4);
        check("pre_rst_field", 8'(field), 8'd6);
        tick(0, 0, 0, 1, 4'd0);
        check("midrst_field", 8'(field), 8'd0);
        check("midrst_hr", 8'(hr), 8'd12);
        check("midrst_load", 8'(load), 8'd0);
        idle_tick();

        // Start edge mid-edit is ignored.
        press_start();
        enter(4'd1);
        tick(1, 0, 0, 0, 4'd0);
        check("restart_field", 8'(field), 8'd2);
        idle_tick();
        press_cancel();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit s, a, c, r;
            logic [3:0] d;
            if ($urandom_range(0, 19) == 0) begin
                cur_sec  = 6'($urandom_range(0, 59));
                cur_min  = 6'($urandom_range(0, 59));
                cur_hr   = 5'($urandom_range(1, 12));
                cur_AMPM = 1'($urandom_range(0, 1));
            end
            s = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 9) < 4);
            c = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            d = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
            tick(s, a, c, r, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
